// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole pipeline.
// Mole selection lives here so every stage picks holes the same way.
package whack_pkg;

   localparam int unsigned NUM_HOLES = 5;
   localparam int unsigned LFSR_W    = 8;
   // Fibonacci taps 8,6,5,4 (bits 7,5,4,3)
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

   typedef logic [NUM_HOLES-1:0] mask_t;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StSpawn,
      StClear,
      StDone
   } spawn_state_e;

   // Folds a 3-bit random value onto the holes and steps past the previous mole.
   function automatic mask_t pick_mole(input logic [2:0] sel, input mask_t prev);
      logic [2:0] idx;
      idx = sel;
      if (idx >= 3'd5) idx = idx - 3'd5;
      if (prev[idx]) idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      return mask_t'(1) << idx;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; exposes the low bits used for hole selection.
// Advances every clock so the pattern depends on when the game starts.
module mole_lfsr
   import whack_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [2:0] rnd
);

   logic [LFSR_W-1:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign rnd = lfsr_q[2:0];

endmodule

// File: rtl/mole_spawner.sv
// Timed mole pattern source: spawns one-hot masks on a tick schedule, speeds up
// on hits, and clears the board after a fixed number of rounds.
module mole_spawner
   import whack_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 4,
   parameter int unsigned BASE_PERIOD    = 3,
   parameter int unsigned MIN_PERIOD     = 1,
   parameter int unsigned STEP           = 1,
   parameter int unsigned HITS_PER_LEVEL = 2,
   parameter int unsigned NUM_ROUNDS     = 3,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 score_trigger,
   output logic                 load,
   output logic [NUM_HOLES-1:0] loadval,
   output logic [7:0]           round_cnt,
   output logic [7:0]           period,
   output logic                 busy,
   output logic                 game_over
);

   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
   localparam logic [7:0] BASE_P     = 8'(BASE_PERIOD);
   localparam logic [7:0] MIN_P      = 8'(MIN_PERIOD);
   localparam logic [7:0] STEP_P     = 8'(STEP);
   localparam logic [7:0] HPL_P      = 8'(HITS_PER_LEVEL);
   localparam logic [7:0] ROUNDS_P   = 8'(NUM_ROUNDS);
   localparam logic [8:0] DEC_LIMIT  = 9'(MIN_PERIOD + STEP);

   spawn_state_e state_q;
   logic [7:0]   presc_q;
   logic [7:0]   tick_cnt_q;
   logic [7:0]   hit_cnt_q;
   logic [7:0]   round_period_q;
   logic [2:0]   rnd;

   logic         running;
   logic [7:0]   hit_inc;
   logic         level_up;
   logic [7:0]   period_dec;
   logic [7:0]   period_d;
   logic         tick;
   logic [7:0]   tick_nxt;
   logic         round_due;

   mole_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .rnd   (rnd)
   );

   always_comb begin
      running    = (state_q == StWait) || (state_q == StSpawn);
      hit_inc    = hit_cnt_q + 8'd1;
      level_up   = running && score_trigger && (hit_inc >= HPL_P);
      // Saturate at the floor without wrapping below zero
      period_dec = ({1'b0, period} >= DEC_LIMIT) ? period - STEP_P : MIN_P;
      period_d   = level_up ? period_dec : period;
      tick       = (presc_q == PRESC_LAST);
      tick_nxt   = tick_cnt_q + 8'd1;
      round_due  = tick && (tick_nxt >= round_period_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         load           <= 1'b0;
         loadval        <= '0;
         round_cnt      <= 8'd0;
         period         <= BASE_P;
         busy           <= 1'b0;
         game_over      <= 1'b0;
         presc_q        <= 8'd0;
         tick_cnt_q     <= 8'd0;
         hit_cnt_q      <= 8'd0;
         round_period_q <= BASE_P;
      end else begin
         load <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q        <= StWait;
                  round_cnt      <= 8'd0;
                  period         <= BASE_P;
                  round_period_q <= BASE_P;
                  hit_cnt_q      <= 8'd0;
                  presc_q        <= 8'd0;
                  tick_cnt_q     <= 8'd0;
                  game_over      <= 1'b0;
                  busy           <= 1'b1;
               end
            end
            // The spawn cycle keeps the prescaler running so rounds stay evenly spaced
            StWait, StSpawn: begin
               if (score_trigger) hit_cnt_q <= level_up ? 8'd0 : hit_inc;
               period  <= period_d;
               state_q <= StWait;
               presc_q <= tick ? 8'd0 : presc_q + 8'd1;
               if (tick) tick_cnt_q <= tick_nxt;
               if (round_due) begin
                  presc_q    <= 8'd0;
                  tick_cnt_q <= 8'd0;
                  load       <= 1'b1;
                  if (round_cnt < ROUNDS_P) begin
                     state_q        <= StSpawn;
                     loadval        <= pick_mole(rnd, loadval);
                     round_cnt      <= (round_cnt == 8'hFF) ? round_cnt : round_cnt + 8'd1;
                     round_period_q <= period_d;
                  end else begin
                     state_q <= StClear;
                     loadval <= '0;
                     busy    <= 1'b0;
                  end
               end
            end
            StClear: begin
               state_q   <= StDone;
               game_over <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mole_spawner.sv
// Randomised bench for mole_spawner: a game-level model predicts each load by
// cycle number and a negedge monitor checks loads and status against it.
module tb_mole_spawner;

   localparam int TICK_DIV       = 4;
   localparam int BASE_PERIOD    = 3;
   localparam int MIN_PERIOD     = 1;
   localparam int STEP           = 1;
   localparam int HITS_PER_LEVEL = 2;
   localparam int NUM_ROUNDS     = 3;
   localparam logic [7:0] SEED   = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       score_trigger = 1'b0;
   logic       load;
   logic [4:0] loadval;
   logic [7:0] round_cnt;
   logic [7:0] period;
   logic       busy;
   logic       game_over;

   mole_spawner #(
      .TICK_DIV       (TICK_DIV),
      .BASE_PERIOD    (BASE_PERIOD),
      .MIN_PERIOD     (MIN_PERIOD),
      .STEP           (STEP),
      .HITS_PER_LEVEL (HITS_PER_LEVEL),
      .NUM_ROUNDS     (NUM_ROUNDS),
      .LFSR_SEED      (SEED)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .score_trigger (score_trigger),
      .load          (load),
      .loadval       (loadval),
      .round_cnt     (round_cnt),
      .period        (period),
      .busy          (busy),
      .game_over     (game_over)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {MIdle, MRun, MClear, MDone} mstate_e;
   typedef struct {
      int mask;
      int rnd;
      int cyc;
   } exp_t;

   exp_t       sb[$];
   mstate_e    mst;
   logic [7:0] m_lfsr;
   int n, due, hits, rp, prev;
   int m_mask, m_round, m_period, m_busy, m_over;

   task automatic model_reset();
      mst      = MIdle;
      m_lfsr   = SEED;
      hits     = 0;
      rp       = BASE_PERIOD;
      prev     = -1;
      m_mask   = 0;
      m_round  = 0;
      m_period = BASE_PERIOD;
      m_busy   = 0;
      m_over   = 0;
      sb.delete();
   endtask

   task automatic model_step();
      logic [7:0] cur;
      int idx;
      cur    = m_lfsr;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      n++;
      case (mst)
         MIdle, MDone: begin
            if (start) begin
               mst      = MRun;
               m_round  = 0;
               m_period = BASE_PERIOD;
               rp       = BASE_PERIOD;
               hits     = 0;
               due      = n + BASE_PERIOD * TICK_DIV;
               m_busy   = 1;
               m_over   = 0;
            end
         end
         MRun: begin
            if (score_trigger) begin
               hits++;
               if (hits >= HITS_PER_LEVEL) begin
                  hits     = 0;
                  m_period = (m_period - STEP < MIN_PERIOD) ? MIN_PERIOD : m_period - STEP;
               end
            end
            if (n == due) begin
               if (m_round < NUM_ROUNDS) begin
                  idx = int'(cur) % 8;
                  if (idx >= 5) idx -= 5;
                  if (idx == prev) idx = (idx + 1) % 5;
                  prev    = idx;
                  m_mask  = 1 << idx;
                  m_round = (m_round < 255) ? m_round + 1 : 255;
                  rp      = m_period;
                  due     = n + rp * TICK_DIV;
               end else begin
                  mst    = MClear;
                  m_mask = 0;
                  prev   = -1;
                  m_busy = 0;
               end
               sb.push_back('{mask: m_mask, rnd: m_round, cyc: n});
            end
         end
         MClear: begin
            mst    = MDone;
            m_over = 1;
         end
         default: mst = MIdle;
      endcase
   endtask

   initial begin
      n = 0;
      due = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (load) begin
            if (sb.size() == 0) begin
               chk("load_when_none_due", int'(load), 0);
            end else begin
               e = sb.pop_front();
               chk("load_cycle", n, e.cyc);
               chk("load_mask", int'(loadval), e.mask);
               chk("load_round", int'(round_cnt), e.rnd);
            end
         end else if (sb.size() > 0 && sb[0].cyc < n) begin
            chk("missed_load", int'(load), 1);
            void'(sb.pop_front());
         end
         chk("loadval", int'(loadval), m_mask);
         chk("round_cnt", int'(round_cnt), m_round);
         chk("period", int'(period), m_period);
         chk("busy", int'(busy), m_busy);
         chk("game_over", int'(game_over), m_over);
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic play(input int hit_pct, input bit rand_start);
      int k;
      k = 0;
      pulse_start();
      while (k < 300) begin
         @(negedge clk);
         if (game_over) break;
         score_trigger = ($urandom_range(0, 99) < hit_pct);
         start = rand_start && ($urandom_range(0, 9) == 0);
         k++;
      end
      start = 1'b0;
      score_trigger = 1'b0;
      chk("game_finished", int'(game_over), 1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_load"}, int'(load), 0);
      chk({tag, "_loadval"}, int'(loadval), 0);
      chk({tag, "_round_cnt"}, int'(round_cnt), 0);
      chk({tag, "_period"}, int'(period), BASE_PERIOD);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values("por");
      rst_n = 1'b1;

      // Idle with stray hits: nothing may load
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         score_trigger = ($urandom_range(0, 3) == 0);
      end
      score_trigger = 1'b0;

      // Clean game, then restart from DONE, then hit-heavy games with stray starts
      play(0, 1'b0);
      repeat (5) @(negedge clk);
      play(0, 1'b0);
      for (int g = 0; g < 6; g++) begin
         play(10 + 15 * g, 1'b1);
         repeat ($urandom_range(0, 7)) @(negedge clk);
      end

      // Asynchronous abort in the middle of a round
      pulse_start();
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("abort");
      @(negedge clk);
      rst_n = 1'b1;
      play(0, 1'b0);
      play(40, 1'b1);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
